multicore_system_sequencer: RTL and testbench

- Parametrised top-level sequencer for the multi-core matrix processor system. It is the successor to the fixed idle/execute/finish controller.
- Owns the instruction and data RAM ports and arbitrates them between three sources: a stream loader (instruction or data memory), the multi-core processor (execute), and a stream dumper (data memory readback).
- Adds repeatable runs, an execution cycle counter and a watchdog timeout.

---
 rtl/multicore_system_sequencer.sv | 169 ++++++++++++++++
 tb/tb_multicore_system_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicore_system_sequencer.sv
// Top-level sequencer: arbitrates instruction/data RAM ports between stream loader, processor execute and stream dumper.
// Loads write in the handshake cycle; dumps take 2 cycles/word; both stall on their handshake, EXEC ends on proc_done or watchdog.
module multicore_system_sequencer #(
  parameter int CORE_COUNT     = 2,
  parameter int REG_WIDTH      = 12,
  parameter int INS_WIDTH      = 8,
  parameter int INS_MEM_DEPTH  = 256,
  parameter int DATA_MEM_DEPTH = 4096,
  parameter int CYC_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 0,
  localparam int DMW = CORE_COUNT * REG_WIDTH,
  localparam int IA  = $clog2(INS_MEM_DEPTH),
  localparam int DA  = $clog2(DATA_MEM_DEPTH),
  localparam int LW  = DA + 1
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 startN,
  input  logic [1:0]           modeSel,
  input  logic [LW-1:0]        xferLen,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [DMW-1:0]       ld_data,
  output logic                 dump_valid,
  input  logic                 dump_ready,
  output logic [DMW-1:0]       dump_data,
  output logic                 proc_startN,
  input  logic                 proc_done,
  input  logic                 proc_ready,
  input  logic [IA-1:0]        proc_insMemAddr,
  input  logic [DA-1:0]        proc_dataMemAddr,
  input  logic [DMW-1:0]       proc_DataOut,
  input  logic                 proc_DataMemWrEn,
  output logic                 insMemWrEn,
  output logic [IA-1:0]        insMemAddr,
  output logic [INS_WIDTH-1:0] insMemIn,
  output logic                 dataMemWrEn,
  output logic [DA-1:0]        dataMemAddr,
  output logic [DMW-1:0]       dataMemIn,
  input  logic [DMW-1:0]       dataMemOut,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic [CYC_WIDTH-1:0] cycleCount
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_INS, S_LOAD_DATA, S_EXEC, S_DUMP_RD, S_DUMP_OUT, S_FINISH
  } state_t;

  state_t               r_state, w_next;
  logic [LW-1:0]        r_ptr, r_len, w_len;
  logic [CYC_WIDTH-1:0] r_cyc;
  logic                 r_timeout;
  logic                 w_idle, w_accept, w_last, w_wd_hit, w_unused;

  assign w_idle   = (r_state == S_IDLE) || (r_state == S_FINISH);
  assign w_accept = rstN && w_idle && !startN;
  assign w_last   = (r_ptr == r_len - LW'(1));
  assign w_wd_hit = (TIMEOUT_CYCLES != 0) && (r_cyc == CYC_WIDTH'(TIMEOUT_CYCLES - 1));
  assign w_unused = proc_ready;

  // Transfer length is clamped to the depth of the memory the command targets.
  always_comb begin
    w_len = xferLen;
    if (modeSel == 2'd1) begin
      if (xferLen > LW'(INS_MEM_DEPTH)) w_len = LW'(INS_MEM_DEPTH);
    end else if (xferLen > LW'(DATA_MEM_DEPTH)) begin
      w_len = LW'(DATA_MEM_DEPTH);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_FINISH: begin
        if (!startN) begin
          case (modeSel)
            2'd0:    w_next = S_EXEC;
            2'd1:    w_next = (w_len == '0) ? S_FINISH : S_LOAD_INS;
            2'd2:    w_next = (w_len == '0) ? S_FINISH : S_LOAD_DATA;
            default: w_next = (w_len == '0) ? S_FINISH : S_DUMP_RD;
          endcase
        end
      end
      S_LOAD_INS, S_LOAD_DATA: if (ld_valid && w_last) w_next = S_FINISH;
      S_EXEC:     if (proc_done || w_wd_hit) w_next = S_FINISH;
      S_DUMP_RD:  w_next = S_DUMP_OUT;
      S_DUMP_OUT: if (dump_ready) w_next = w_last ? S_FINISH : S_DUMP_RD;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_len     <= '0;
      r_cyc     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_ptr     <= '0;
        r_len     <= w_len;
        r_timeout <= 1'b0;
        if (modeSel == 2'd0) r_cyc <= '0;
      end
      case (r_state)
        S_LOAD_INS, S_LOAD_DATA: if (ld_valid) r_ptr <= r_ptr + LW'(1);
        // The proc_done cycle is counted; a watchdog expiry leaves the count at the limit minus one.
        S_EXEC: begin
          if (proc_done)     r_cyc     <= r_cyc + CYC_WIDTH'(1);
          else if (w_wd_hit) r_timeout <= 1'b1;
          else               r_cyc     <= r_cyc + CYC_WIDTH'(1);
        end
        S_DUMP_OUT: if (dump_ready && !w_last) r_ptr <= r_ptr + LW'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    ld_ready    = 1'b0;
    insMemWrEn  = 1'b0;
    insMemAddr  = '0;
    insMemIn    = '0;
    dataMemWrEn = 1'b0;
    dataMemAddr = '0;
    dataMemIn   = '0;
    dump_valid  = 1'b0;
    dump_data   = '0;
    busy        = !w_idle;
    done        = (r_state == S_FINISH);
    proc_startN = !(w_accept && (modeSel == 2'd0));
    case (r_state)
      S_LOAD_INS: begin
        ld_ready   = 1'b1;
        insMemWrEn = ld_valid;
        insMemAddr = r_ptr[IA-1:0];
        insMemIn   = ld_data[INS_WIDTH-1:0];
      end
      S_LOAD_DATA: begin
        ld_ready    = 1'b1;
        dataMemWrEn = ld_valid;
        dataMemAddr = r_ptr[DA-1:0];
        dataMemIn   = ld_data;
      end
      S_EXEC: begin
        insMemAddr  = proc_insMemAddr;
        dataMemAddr = proc_dataMemAddr;
        dataMemIn   = proc_DataOut;
        dataMemWrEn = proc_DataMemWrEn;
      end
      S_DUMP_RD: dataMemAddr = r_ptr[DA-1:0];
      // Address is held so the RAM keeps presenting the same word while the consumer stalls.
      S_DUMP_OUT: begin
        dataMemAddr = r_ptr[DA-1:0];
        dump_valid  = 1'b1;
        dump_data   = dataMemOut;
      end
      default: ;
    endcase
  end

  assign timeout    = r_timeout;
  assign cycleCount = r_cyc;

endmodule

// File: tb/tb_multicore_system_sequencer.sv
// Directed bench for multicore_system_sequencer with behavioural instruction/data RAMs.
module tb_multicore_system_sequencer;

  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rstN, startN;
  logic [1:0]  modeSel;
  logic [12:0] xferLen;
  logic        ld_valid, ld_ready;
  logic [23:0] ld_data;
  logic        dump_valid, dump_ready;
  logic [23:0] dump_data;
  logic        proc_startN, proc_done, proc_ready;
  logic [7:0]  proc_insMemAddr;
  logic [11:0] proc_dataMemAddr;
  logic [23:0] proc_DataOut;
  logic        proc_DataMemWrEn;
  logic        insMemWrEn;
  logic [7:0]  insMemAddr, insMemIn;
  logic        dataMemWrEn;
  logic [11:0] dataMemAddr;
  logic [23:0] dataMemIn, dataMemOut;
  logic        busy, done, timeout;
  logic [31:0] cycleCount;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]  iram [256];
  logic [23:0] dram [4096];
  logic [23:0] dv   [3];

  always #5 clk = ~clk;

  multicore_system_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rstN(rstN), .startN(startN), .modeSel(modeSel), .xferLen(xferLen),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
    .proc_startN(proc_startN), .proc_done(proc_done), .proc_ready(proc_ready),
    .proc_insMemAddr(proc_insMemAddr), .proc_dataMemAddr(proc_dataMemAddr),
    .proc_DataOut(proc_DataOut), .proc_DataMemWrEn(proc_DataMemWrEn),
    .insMemWrEn(insMemWrEn), .insMemAddr(insMemAddr), .insMemIn(insMemIn),
    .dataMemWrEn(dataMemWrEn), .dataMemAddr(dataMemAddr), .dataMemIn(dataMemIn),
    .dataMemOut(dataMemOut), .busy(busy), .done(done), .timeout(timeout),
    .cycleCount(cycleCount)
  );

  always @(posedge clk) begin
    if (insMemWrEn) iram[insMemAddr] <= insMemIn;
    if (dataMemWrEn) dram[dataMemAddr] <= dataMemIn;
    dataMemOut <= dram[dataMemAddr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int k;
    dv[0] = 24'hABC123; dv[1] = 24'h5A5A5A; dv[2] = 24'h000777;
    rstN = 1'b0; startN = 1'b1; modeSel = 2'd0; xferLen = '0;
    ld_valid = 1'b0; ld_data = '0; dump_ready = 1'b0;
    proc_done = 1'b0; proc_ready = 1'b1; proc_insMemAddr = '0; proc_dataMemAddr = '0;
    proc_DataOut = '0; proc_DataMemWrEn = 1'b0;

    // Reset state
    tick(); tick(); #1;
    chk("rst_busy", busy, 0);         chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);   chk("rst_cyc", cycleCount, 0);
    chk("rst_pstart", proc_startN, 1); chk("rst_ldrdy", ld_ready, 0);
    chk("rst_dvalid", dump_valid, 0); chk("rst_iwe", insMemWrEn, 0);
    chk("rst_dwe", dataMemWrEn, 0);   chk("rst_daddr", dataMemAddr, 0);
    rstN = 1'b1;

    // LOAD_INS, 4 words back to back
    tick(); startN = 1'b0; modeSel = 2'd1; xferLen = 13'd4; #1;
    chk("li_accept_pstart", proc_startN, 1); chk("li_accept_busy", busy, 0);
    for (int i = 0; i < 4; i++) begin
      tick(); startN = 1'b1; ld_valid = 1'b1; ld_data = 24'(8'h11 * (i + 1)); #1;
      chk("li_busy", busy, 1); chk("li_ldrdy", ld_ready, 1); chk("li_we", insMemWrEn, 1);
      chk("li_addr", insMemAddr, i); chk("li_din", insMemIn, 8'h11 * (i + 1));
    end
    tick(); ld_valid = 1'b0; #1;
    chk("li_done", done, 1); chk("li_busy_end", busy, 0);
    chk("li_ldrdy_end", ld_ready, 0); chk("li_we_end", insMemWrEn, 0);
    chk("li_ram0", iram[0], 8'h11); chk("li_ram3", iram[3], 8'h44);

    // LOAD_DATA, 3 words with ld_valid toggling
    tick(); startN = 1'b0; modeSel = 2'd2; xferLen = 13'd3; #1;
    k = 0;
    for (int i = 0; i < 5; i++) begin
      tick(); startN = 1'b1; ld_valid = (i % 2 == 0);
      ld_data = ld_valid ? dv[k] : 24'hFFFFFF; #1;
      chk("ld_we", dataMemWrEn, ld_valid);
      if (ld_valid) begin
        chk("ld_addr", dataMemAddr, k);
        k++;
      end
    end
    tick(); ld_valid = 1'b0; #1;
    chk("ld_done", done, 1); chk("ld_busy_end", busy, 0);
    chk("ld_ram0", dram[0], 24'hABC123); chk("ld_ram1", dram[1], 24'h5A5A5A);
    chk("ld_ram2", dram[2], 24'h000777);

    // Zero-length load goes straight to FINISH
    tick(); startN = 1'b0; modeSel = 2'd2; xferLen = 13'd0; #1;
    tick(); startN = 1'b1; #1;
    chk("len0_busy", busy, 0); chk("len0_ldrdy", ld_ready, 0); chk("len0_done", done, 1);

    // EXEC, proc_done 37 cycles after the start pulse
    tick(); startN = 1'b0; modeSel = 2'd0; #1;
    chk("ex_pstart_pulse", proc_startN, 0);
    for (int e = 1; e <= 37; e++) begin
      tick(); startN = 1'b1; proc_done = (e == 37);
      proc_insMemAddr = 8'h3C; proc_dataMemAddr = 12'h5A5;
      proc_DataOut = 24'h123456; proc_DataMemWrEn = 1'b1; #1;
      chk("ex_pstart_high", proc_startN, 1);
      if (e == 1) begin
        chk("ex_cyc_clear", cycleCount, 0); chk("ex_iaddr", insMemAddr, 8'h3C);
        chk("ex_daddr", dataMemAddr, 12'h5A5); chk("ex_din", dataMemIn, 24'h123456);
        chk("ex_dwe", dataMemWrEn, 1); chk("ex_iwe", insMemWrEn, 0); chk("ex_busy", busy, 1);
      end
    end
    tick(); proc_done = 1'b0; #1;
    chk("ex_done", done, 1); chk("ex_timeout", timeout, 0); chk("ex_cyc", cycleCount, 37);
    chk("ex_busy_end", busy, 0); chk("ex_ignore_daddr", dataMemAddr, 0);
    chk("ex_ignore_dwe", dataMemWrEn, 0);
    proc_DataMemWrEn = 1'b0; proc_insMemAddr = '0; proc_dataMemAddr = '0; proc_DataOut = '0;

    // EXEC with no proc_done: watchdog expires after TMO cycles
    tick(); startN = 1'b0; modeSel = 2'd0; #1;
    for (int e = 1; e <= TMO; e++) begin
      tick(); startN = 1'b1; #1;
      if (e == TMO) begin
        chk("wd_busy_last", busy, 1); chk("wd_tmo_pending", timeout, 0);
      end
    end
    tick(); #1;
    chk("wd_timeout", timeout, 1); chk("wd_cyc", cycleCount, TMO - 1);
    chk("wd_done", done, 1); chk("wd_busy", busy, 0);

    // New EXEC clears timeout; proc_done on the watchdog cycle wins
    tick(); startN = 1'b0; modeSel = 2'd0; #1;
    chk("wd2_pstart", proc_startN, 0);
    for (int e = 1; e <= TMO; e++) begin
      tick(); startN = 1'b1; proc_done = (e == TMO); #1;
      if (e == 1) begin
        chk("wd2_tmo_clear", timeout, 0); chk("wd2_cyc_clear", cycleCount, 0);
      end
    end
    tick(); proc_done = 1'b0; #1;
    chk("race_timeout", timeout, 0); chk("race_cyc", cycleCount, TMO); chk("race_done", done, 1);

    // DUMP 2 words with 3 stall cycles on the first
    tick(); startN = 1'b0; modeSel = 2'd3; xferLen = 13'd2; #1;
    tick(); startN = 1'b1; dump_ready = 1'b0; #1;
    chk("du_rd_addr", dataMemAddr, 0); chk("du_rd_valid", dump_valid, 0); chk("du_rd_busy", busy, 1);
    for (int s = 0; s < 3; s++) begin
      tick(); #1;
      chk("du_stall_valid", dump_valid, 1); chk("du_stall_data", dump_data, 24'hABC123);
    end
    tick(); dump_ready = 1'b1; #1;
    chk("du_hs0_data", dump_data, 24'hABC123); chk("du_hs0_valid", dump_valid, 1);
    tick(); dump_ready = 1'b0; #1;
    chk("du_rd1_valid", dump_valid, 0); chk("du_rd1_addr", dataMemAddr, 1); chk("du_rd1_busy", busy, 1);
    tick(); dump_ready = 1'b1; #1;
    chk("du_hs1_valid", dump_valid, 1); chk("du_hs1_data", dump_data, 24'h5A5A5A);
    tick(); dump_ready = 1'b0; #1;
    chk("du_done", done, 1); chk("du_valid_end", dump_valid, 0); chk("du_busy_end", busy, 0);

    // LOAD_INS longer than the RAM is clamped to 256 words
    tick(); startN = 1'b0; modeSel = 2'd1; xferLen = 13'd300; #1;
    for (int i = 0; i < 256; i++) begin
      tick(); startN = 1'b1; ld_valid = 1'b1; ld_data = 24'(i); #1;
      if (i == 255) begin
        chk("clamp_addr", insMemAddr, 8'hFF); chk("clamp_busy", busy, 1);
      end
    end
    tick(); ld_valid = 1'b0; #1;
    chk("clamp_done", done, 1); chk("clamp_busy_end", busy, 0);
    chk("clamp_ram255", iram[255], 8'hFF); chk("clamp_ram0", iram[0], 8'h00);

    // Reset mid-LOAD_DATA at pointer 5, startN pulse while busy ignored
    tick(); startN = 1'b0; modeSel = 2'd2; xferLen = 13'd10; #1;
    for (int i = 0; i < 5; i++) begin
      tick(); startN = 1'b1; ld_valid = 1'b1; ld_data = 24'h600 + 24'(i); #1;
    end
    tick(); ld_valid = 1'b0; startN = 1'b0; modeSel = 2'd0; #1;
    chk("mid_pstart_busy", proc_startN, 1); chk("mid_busy", busy, 1); chk("mid_addr", dataMemAddr, 5);
    tick(); startN = 1'b1; #1;
    chk("mid_still_load", ld_ready, 1); chk("mid_addr_hold", dataMemAddr, 5);
    rstN = 1'b0; ld_valid = 1'b1; modeSel = 2'd2;
    tick(); #1;
    chk("mrst_busy", busy, 0); chk("mrst_done", done, 0); chk("mrst_ldrdy", ld_ready, 0);
    chk("mrst_dwe", dataMemWrEn, 0); chk("mrst_daddr", dataMemAddr, 0);
    chk("mrst_cyc", cycleCount, 0); chk("mrst_tmo", timeout, 0); chk("mrst_pstart", proc_startN, 1);
    rstN = 1'b1; ld_valid = 1'b0;
    tick(); #1;
    chk("post_idle_busy", busy, 0); chk("post_idle_done", done, 0);
    startN = 1'b0; modeSel = 2'd2; xferLen = 13'd1;
    tick(); startN = 1'b1; ld_valid = 1'b1; ld_data = 24'h0C0FFE; #1;
    chk("post_ptr0_addr", dataMemAddr, 0); chk("post_ptr0_we", dataMemWrEn, 1);
    tick(); ld_valid = 1'b0; #1;
    chk("post_done", done, 1); chk("post_ram0", dram[0], 24'h0C0FFE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
